// File: rtl/sensor_sequencer.sv
// Image-sensor frame sequencer: erase, optional reference (CDS) conversion, expose,
// signal conversion and handshaked pixel readout, with continuous mode and abort.
module sensor_sequencer #(
    parameter int PIXEL_COUNT  = 4,
    parameter int CNT_W        = 16,
    parameter int ERASE_CYCLES = 5,
    localparam int PIX_W       = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cont_mode,
    input  logic             cds,
    input  logic             abort,
    input  logic [CNT_W-1:0] expose_cycles,
    input  logic [CNT_W-1:0] convert_cycles,
    input  logic             read_ready,
    output logic             idle,
    output logic             erase,
    output logic             expose,
    output logic             convert,
    output logic             read,
    output logic             corr,
    output logic [PIX_W-1:0] pixel_select,
    output logic             frame_done,
    output logic [15:0]      frame_count
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ERASE  = 3'd1;
    localparam logic [2:0] ST_REF    = 3'd2;
    localparam logic [2:0] ST_EXPOSE = 3'd3;
    localparam logic [2:0] ST_SIG    = 3'd4;
    localparam logic [2:0] ST_READ   = 3'd5;

    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(PIXEL_COUNT - 1);

    logic [2:0]       state_r;
    logic [2:0]       state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic [CNT_W-1:0] exp_sh_r;
    logic [CNT_W-1:0] conv_sh_r;
    logic             cds_sh_r;
    logic [PIX_W-1:0] pix_nx_s;
    logic             done_s;
    logic             latch_s;

    // Final count value for a latched duration; zero is stretched to a single cycle.
    function automatic logic [CNT_W-1:0] last_of(input logic [CNT_W-1:0] dur);
        if (dur == {CNT_W{1'b0}}) begin
            return {CNT_W{1'b0}};
        end else begin
            return dur - CNT_W'(1);
        end
    endfunction

    // Next-state, counter, pixel index and frame-completion decode.
    always_comb begin
        state_nx_s = state_r;
        pix_nx_s   = {PIX_W{1'b0}};
        done_s     = 1'b0;
        latch_s    = 1'b0;
        cnt_nx_s   = {CNT_W{1'b0}};
        if (abort) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_nx_s = ST_ERASE;
                        latch_s    = 1'b1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_ERASE: begin
                    if (cnt_r == ERASE_LAST) begin
                        state_nx_s = cds_sh_r ? ST_REF : ST_EXPOSE;
                    end else begin
                        state_nx_s = ST_ERASE;
                    end
                end
                ST_REF: begin
                    if (cnt_r == last_of(conv_sh_r)) begin
                        state_nx_s = ST_EXPOSE;
                    end else begin
                        state_nx_s = ST_REF;
                    end
                end
                ST_EXPOSE: begin
                    if (cnt_r == last_of(exp_sh_r)) begin
                        state_nx_s = ST_SIG;
                    end else begin
                        state_nx_s = ST_EXPOSE;
                    end
                end
                ST_SIG: begin
                    if (cnt_r == last_of(conv_sh_r)) begin
                        state_nx_s = ST_READ;
                    end else begin
                        state_nx_s = ST_SIG;
                    end
                end
                ST_READ: begin
                    if (read_ready && (pixel_select == PIX_LAST)) begin
                        done_s     = 1'b1;
                        latch_s    = cont_mode;
                        state_nx_s = cont_mode ? ST_ERASE : ST_IDLE;
                    end else if (read_ready) begin
                        pix_nx_s = pixel_select + PIX_W'(1);
                    end else begin
                        pix_nx_s = pixel_select;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
        // Timed states count from zero on entry; IDLE and READ keep the counter parked.
        if ((state_nx_s != state_r) || (state_nx_s == ST_IDLE) || (state_nx_s == ST_READ)) begin
            cnt_nx_s = {CNT_W{1'b0}};
        end else begin
            cnt_nx_s = cnt_r + CNT_W'(1);
        end
    end

    // State, counter, frame parameters and registered output decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            exp_sh_r     <= {CNT_W{1'b0}};
            conv_sh_r    <= {CNT_W{1'b0}};
            cds_sh_r     <= 1'b0;
            idle         <= 1'b1;
            erase        <= 1'b0;
            expose       <= 1'b0;
            convert      <= 1'b0;
            read         <= 1'b0;
            corr         <= 1'b0;
            pixel_select <= {PIX_W{1'b0}};
            frame_done   <= 1'b0;
            frame_count  <= 16'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            if (latch_s) begin
                exp_sh_r  <= expose_cycles;
                conv_sh_r <= convert_cycles;
                cds_sh_r  <= cds;
            end
            idle         <= (state_nx_s == ST_IDLE);
            erase        <= (state_nx_s == ST_ERASE);
            expose       <= (state_nx_s == ST_EXPOSE);
            convert      <= (state_nx_s == ST_REF) || (state_nx_s == ST_SIG);
            read         <= (state_nx_s == ST_READ);
            corr         <= (state_nx_s == ST_REF);
            pixel_select <= pix_nx_s;
            frame_done   <= done_s;
            if (done_s) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sensor_sequencer.sv
// Scoreboard bench for sensor_sequencer: each scenario queues the expected per-cycle
// output vector {idle,erase,expose,convert,read,corr,pixel_select,frame_done}.
module tb_sensor_sequencer;

    localparam logic [4:0] S_IDLE  = 5'b10000;
    localparam logic [4:0] S_ERASE = 5'b01000;
    localparam logic [4:0] S_EXP   = 5'b00100;
    localparam logic [4:0] S_CONV  = 5'b00010;
    localparam logic [4:0] S_READ  = 5'b00001;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cont_mode;
    logic        cds;
    logic        abort;
    logic [15:0] expose_cycles;
    logic [15:0] convert_cycles;
    logic        read_ready;
    logic        idle, erase, expose, convert, read, corr, frame_done;
    logic [1:0]  pixel_select;
    logic [15:0] frame_count;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  exp_v;
    logic [8:0]  obs;

    assign obs = {idle, erase, expose, convert, read, corr, pixel_select, frame_done};

    always #5 clk = ~clk;

    sensor_sequencer #(.PIXEL_COUNT(4), .CNT_W(16), .ERASE_CYCLES(5)) dut (
        .clk(clk), .reset(reset), .enable(enable), .cont_mode(cont_mode), .cds(cds),
        .abort(abort), .expose_cycles(expose_cycles), .convert_cycles(convert_cycles),
        .read_ready(read_ready), .idle(idle), .erase(erase), .expose(expose),
        .convert(convert), .read(read), .corr(corr), .pixel_select(pixel_select),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    function automatic logic [8:0] ev(input logic [4:0] st, input logic c, input logic [1:0] p,
                                      input logic d);
        return {st, c, p, d};
    endfunction

    task automatic push(input logic [8:0] v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic push_read();
        for (int k = 0; k < 4; k++) push(ev(S_READ, 1'b0, k[1:0], 1'b0), 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; cont_mode = 1'b0; cds = 1'b0; abort = 1'b0;
        expose_cycles = 16'd10; convert_cycles = 16'd8; read_ready = 1'b1;
        #3;
        total_cnt++;
        if (obs !== ev(S_IDLE, 1'b0, 2'd0, 1'b0)) $display("FAIL reset_outputs: got %b, expected %b", obs, ev(S_IDLE, 1'b0, 2'd0, 1'b0));
        else pass_cnt++;
        total_cnt++;
        if (frame_count !== 16'd0) $display("FAIL reset_count: got %0d, expected 0", frame_count);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (obs !== ev(S_IDLE, 1'b0, 2'd0, 1'b0)) $display("FAIL reset_held: got %b, expected %b", obs, ev(S_IDLE, 1'b0, 2'd0, 1'b0));
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int i = 0;
        enable = 1'b1;
        push(ev(S_ERASE, 1'b0, 2'd0, 1'b0), 5);
        push(ev(S_EXP, 1'b0, 2'd0, 1'b0), 10);
        push(ev(S_CONV, 1'b0, 2'd0, 1'b0), 8);
        push_read();
        push(ev(S_IDLE, 1'b0, 2'd0, 1'b1), 1);
        push(ev(S_IDLE, 1'b0, 2'd0, 1'b0), 2);
        while (exp_q.size() > 0) begin
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (obs !== exp_v) $display("FAIL basic_trace step %0d: got %b, expected %b", i, obs, exp_v);
            else pass_cnt++;
            enable = 1'b0;
            i++;
        end
        total_cnt++;
        if (frame_count !== 16'd1) $display("FAIL basic_count: got %0d, expected 1", frame_count);
        else pass_cnt++;
    endtask

    task automatic test_cds();
        int i = 0;
        cds = 1'b1;
        enable = 1'b1;
        push(ev(S_ERASE, 1'b0, 2'd0, 1'b0), 5);
        push(ev(S_CONV, 1'b1, 2'd0, 1'b0), 8);
        push(ev(S_EXP, 1'b0, 2'd0, 1'b0), 10);
        push(ev(S_CONV, 1'b0, 2'd0, 1'b0), 8);
        push_read();
        push(ev(S_IDLE, 1'b0, 2'd0, 1'b1), 1);
        push(ev(S_IDLE, 1'b0, 2'd0, 1'b0), 2);
        while (exp_q.size() > 0) begin
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (obs !== exp_v) $display("FAIL cds_trace step %0d: got %b, expected %b", i, obs, exp_v);
            else pass_cnt++;
            // enable stays high through the whole frame and must be ignored until IDLE
            if (exp_v[8]) enable = 1'b0;
            i++;
        end
        cds = 1'b0;
        total_cnt++;
        if (frame_count !== 16'd2) $display("FAIL cds_count: got %0d, expected 2", frame_count);
        else pass_cnt++;
    endtask

    task automatic test_read_ready();
        int i  = 0;
        int rk = 0;
        read_ready = 1'b0;
        enable = 1'b1;
        push(ev(S_ERASE, 1'b0, 2'd0, 1'b0), 5);
        push(ev(S_EXP, 1'b0, 2'd0, 1'b0), 10);
        push(ev(S_CONV, 1'b0, 2'd0, 1'b0), 8);
        for (int k = 0; k < 4; k++) push(ev(S_READ, 1'b0, k[1:0], 1'b0), 2);
        push(ev(S_IDLE, 1'b0, 2'd0, 1'b1), 1);
        push(ev(S_IDLE, 1'b0, 2'd0, 1'b0), 1);
        while (exp_q.size() > 0) begin
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (obs !== exp_v) $display("FAIL ready_trace step %0d: got %b, expected %b", i, obs, exp_v);
            else pass_cnt++;
            enable = 1'b0;
            if (exp_v[4]) begin
                read_ready = rk[0];
                rk++;
            end
            i++;
        end
        read_ready = 1'b1;
        total_cnt++;
        if (frame_count !== 16'd3) $display("FAIL ready_count: got %0d, expected 3", frame_count);
        else pass_cnt++;
    endtask

    task automatic test_cont_mode();
        int i     = 0;
        int ndone = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if (frame_count !== 16'd0) $display("FAIL cont_reset_count: got %0d, expected 0", frame_count);
        else pass_cnt++;
        cont_mode = 1'b1;
        expose_cycles = 16'd10;
        enable = 1'b1;
        push(ev(S_ERASE, 1'b0, 2'd0, 1'b0), 5);
        push(ev(S_EXP, 1'b0, 2'd0, 1'b0), 10);
        push(ev(S_CONV, 1'b0, 2'd0, 1'b0), 8);
        push_read();
        for (int f = 0; f < 2; f++) begin
            push(ev(S_ERASE, 1'b0, 2'd0, 1'b1), 1);
            push(ev(S_ERASE, 1'b0, 2'd0, 1'b0), 4);
            push(ev(S_EXP, 1'b0, 2'd0, 1'b0), 3);
            push(ev(S_CONV, 1'b0, 2'd0, 1'b0), 8);
            push_read();
        end
        push(ev(S_IDLE, 1'b0, 2'd0, 1'b1), 1);
        push(ev(S_IDLE, 1'b0, 2'd0, 1'b0), 1);
        while (exp_q.size() > 0) begin
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (obs !== exp_v) $display("FAIL cont_trace step %0d: got %b, expected %b", i, obs, exp_v);
            else pass_cnt++;
            enable = 1'b0;
            if (i == 2) expose_cycles = 16'd3;
            if (exp_v[0] && exp_v[7]) ndone++;
            if (ndone == 2) cont_mode = 1'b0;
            i++;
        end
        total_cnt++;
        if (frame_count !== 16'd3) $display("FAIL cont_count: got %0d, expected 3", frame_count);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int i = 0;
        expose_cycles = 16'd10;
        enable = 1'b1;
        push(ev(S_ERASE, 1'b0, 2'd0, 1'b0), 5);
        push(ev(S_EXP, 1'b0, 2'd0, 1'b0), 3);
        push(ev(S_IDLE, 1'b0, 2'd0, 1'b0), 2);
        while (exp_q.size() > 0) begin
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (obs !== exp_v) $display("FAIL abort_trace step %0d: got %b, expected %b", i, obs, exp_v);
            else pass_cnt++;
            enable = 1'b0;
            abort = (i == 7);
            i++;
        end
        total_cnt++;
        if (frame_count !== 16'd3) $display("FAIL abort_count: got %0d, expected 3", frame_count);
        else pass_cnt++;

        i = 0;
        expose_cycles = 16'd0;
        enable = 1'b1;
        push(ev(S_ERASE, 1'b0, 2'd0, 1'b0), 5);
        push(ev(S_EXP, 1'b0, 2'd0, 1'b0), 1);
        push(ev(S_CONV, 1'b0, 2'd0, 1'b0), 8);
        push_read();
        push(ev(S_IDLE, 1'b0, 2'd0, 1'b1), 1);
        push(ev(S_IDLE, 1'b0, 2'd0, 1'b0), 1);
        while (exp_q.size() > 0) begin
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (obs !== exp_v) $display("FAIL zero_expose_trace step %0d: got %b, expected %b", i, obs, exp_v);
            else pass_cnt++;
            enable = 1'b0;
            i++;
        end
        total_cnt++;
        if (frame_count !== 16'd4) $display("FAIL zero_expose_count: got %0d, expected 4", frame_count);
        else pass_cnt++;

        // abort together with enable in IDLE must keep the sequencer idle
        i = 0;
        enable = 1'b1;
        abort = 1'b1;
        push(ev(S_IDLE, 1'b0, 2'd0, 1'b0), 2);
        while (exp_q.size() > 0) begin
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (obs !== exp_v) $display("FAIL abort_idle step %0d: got %b, expected %b", i, obs, exp_v);
            else pass_cnt++;
            enable = 1'b0;
            abort = 1'b0;
            i++;
        end
        expose_cycles = 16'd10;
    endtask

    task automatic test_reset_mid_read();
        int i = 0;
        enable = 1'b1;
        push(ev(S_ERASE, 1'b0, 2'd0, 1'b0), 5);
        push(ev(S_EXP, 1'b0, 2'd0, 1'b0), 10);
        push(ev(S_CONV, 1'b0, 2'd0, 1'b0), 8);
        push(ev(S_READ, 1'b0, 2'd0, 1'b0), 1);
        push(ev(S_READ, 1'b0, 2'd1, 1'b0), 1);
        while (exp_q.size() > 0) begin
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (obs !== exp_v) $display("FAIL midread_trace step %0d: got %b, expected %b", i, obs, exp_v);
            else pass_cnt++;
            enable = 1'b0;
            i++;
        end
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (obs !== ev(S_IDLE, 1'b0, 2'd0, 1'b0)) $display("FAIL midread_async_reset: got %b, expected %b", obs, ev(S_IDLE, 1'b0, 2'd0, 1'b0));
        else pass_cnt++;
        total_cnt++;
        if (frame_count !== 16'd0) $display("FAIL midread_count: got %0d, expected 0", frame_count);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        tick();
        total_cnt++;
        if (obs !== ev(S_IDLE, 1'b0, 2'd0, 1'b0)) $display("FAIL post_reset_idle: got %b, expected %b", obs, ev(S_IDLE, 1'b0, 2'd0, 1'b0));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cds();
        test_read_ready();
        test_cont_mode();
        test_abort();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sensor_sequencer.md
SENSOR_SEQUENCER -- requirements
Module: sensor_sequencer

Interface
REQ-001 SHALL have parameter PIXEL_COUNT, default 4, number of pixels read per frame (>=1).
REQ-002 SHALL have parameter CNT_W, default 16, width of duration inputs and internal counter.
REQ-003 SHALL have parameter ERASE_CYCLES, default 5, fixed erase duration in cycles (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  frame start request, honoured only in IDLE.
REQ-007 SHALL have port cont_mode  input  1  high at end of READ restarts at ERASE.
REQ-008 SHALL have port cds  input  1  enables reference conversion before exposure.
REQ-009 SHALL have port abort  input  1  terminates any frame in progress.
REQ-010 SHALL have port expose_cycles  input  CNT_W  exposure duration.
REQ-011 SHALL have port convert_cycles  input  CNT_W  duration of each conversion.
REQ-012 SHALL have port read_ready  input  1  downstream accepts the current pixel.
REQ-013 SHALL have ports idle, erase, expose, convert, read  output  1 each  state indicators.
REQ-014 SHALL have port corr  output  1  high during the reference conversion only.
REQ-015 SHALL have port pixel_select  output  max(1, ceil(log2 PIXEL_COUNT))  current pixel index.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse per completed frame.
REQ-017 SHALL have port frame_count  output  16  completed-frame count; wraps 0xFFFF -> 0.

Function
REQ-018 SHALL implement states IDLE, ERASE, REF_CONV, EXPOSE, SIG_CONV, READ; all outputs registered.
REQ-019 SHALL assert exactly one of idle/erase/expose/convert/read each cycle; convert high in REF_CONV and SIG_CONV.
REQ-020 SHALL move IDLE -> ERASE on an edge with enable=1 and abort=0; erase high from the following cycle.
REQ-021 SHALL latch expose_cycles, convert_cycles, cds into shadow registers on every ERASE entry; later input changes affect only the next frame.
REQ-022 SHALL clear the duration counter on every state entry; a duration of N keeps the state exactly N cycles.
REQ-023 SHALL treat a latched duration of 0 as 1.
REQ-024 SHALL leave ERASE after ERASE_CYCLES to REF_CONV if latched cds=1, else to EXPOSE.
REQ-025 SHALL go REF_CONV -> EXPOSE after convert duration; corr=1 throughout REF_CONV, 0 elsewhere.
REQ-026 SHALL go EXPOSE -> SIG_CONV after expose duration, and SIG_CONV -> READ after convert duration.
REQ-027 SHALL start READ with pixel_select=0 and advance by one only on cycles with read_ready=1.
REQ-028 SHALL end READ on the edge accepting pixel PIXEL_COUNT-1, then: cont_mode=1 -> ERASE, else IDLE.
REQ-029 SHALL pulse frame_done for the one cycle after that final acceptance and increment frame_count on the same edge.
REQ-030 SHALL hold pixel_select at 0 outside READ.
REQ-031 SHALL return to IDLE on the edge after abort=1 from any non-IDLE state, with no frame_done and no frame_count change.
REQ-032 SHALL give abort priority over enable, durations, and read_ready; abort=1 with enable=1 in IDLE stays IDLE.
REQ-033 SHALL ignore enable outside IDLE.

Reset
REQ-034 SHALL on reset=1 immediately force IDLE: idle=1, all other 1-bit outputs 0, pixel_select=0, frame_count=0, counter and shadow registers 0.
REQ-035 SHALL begin operation at the first rising edge after reset deasserts, with reset mid-frame discarding that frame.

Verification (PIXEL_COUNT=4, ERASE_CYCLES=5, expose_cycles=10, convert_cycles=8 unless stated)
REQ-036 SHALL verify: cds=0, read_ready=1, enable pulse -> erase 5, expose 10, convert 8 (corr=0), read 4 with pixel_select 0,1,2,3, one frame_done, frame_count=1, then idle.
REQ-037 SHALL verify: cds=1 -> erase 5, convert 8 with corr=1, expose 10, convert 8 with corr=0, read 4.
REQ-038 SHALL verify: read_ready alternating 0,1 from READ entry -> each index held 2 cycles, read lasts 8 cycles, frame_done once.
REQ-039 SHALL verify: cont_mode=1, expose_cycles changed 10 -> 3 during frame 1 -> frame 1 exposes 10 and frame 2 exposes 3; after 3 frames frame_count=3.
REQ-040 SHALL verify: abort in EXPOSE cycle 3 -> idle next cycle, frame_count unchanged; expose_cycles=0 -> expose high exactly 1 cycle.
REQ-041 SHALL verify: reset asserted mid-READ between edges -> idle=1, read=0, pixel_select=0 immediately, without waiting for a clock edge.
